cache_ctrl_dm: RTL and testbench
================================

Name: cache_ctrl_dm

Overview:
Direct-mapped, write-back, write-allocate cache controller that sits directly upstream of the block memory model on the cache/memory interface. It accepts single-word CPU loads and stores and serves hits locally. On a miss it evicts a dirty victim line, then refills the line from memory as one full-block transfer. It is the requester on the cache/memory interface; memory is the responder.

Parameters:
ADDR_W, 32, CPU byte-address width
BLOCK_BYTES, 16, bytes per line; equals the memory block size
WORD_BYTES, 4, bytes per CPU access
NUM_LINES, 64, number of lines; power of two

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
cpu_req_valid  in  1  CPU request strobe; held until accepted
cpu_req_ready  out  1  high only in IDLE; request accepted when valid&&ready
cpu_write  in  1  1=store, 0=load
cpu_addr  in  ADDR_W  byte address, word-aligned
cpu_wdata  in  8*WORD_BYTES  store data
cpu_resp_valid  out  1  one-cycle pulse per accepted request
cpu_rdata  out  8*WORD_BYTES  load data, valid with cpu_resp_valid
mem_req_valid  out  1  one-cycle request pulse to memory
mem_write  out  1  1=write-back, 0=fill
mem_addr  out  ADDR_W-log2(BLOCK_BYTES)  block address
mem_data_out  out  8*BLOCK_BYTES  write-back line data
mem_data_in  in  8*BLOCK_BYTES  fill data
mem_ready  in  1  memory idle/done; drops after a request, rises on completion

Behaviour:
- Reset, with rst sampled high at posedge:
  - all valid and dirty bits clear; state IDLE.
  - cpu_req_ready=1, cpu_resp_valid=0, cpu_rdata=0.
  - mem_req_valid=0, mem_write=0, mem_addr=0, mem_data_out=0.
  - Reset mid-transaction abandons it; no response is issued. Tag and data arrays are not cleared.
- Address split: offset = log2(BLOCK_BYTES) LSBs; index = next log2(NUM_LINES) bits; tag = the rest. Word select = offset/WORD_BYTES.
- States: IDLE, WB_REQ, WB_WAIT_LO, WB_WAIT_HI, FILL_REQ, FILL_WAIT_LO, FILL_WAIT_HI, RESP.
- IDLE:
  - On accept, latch write, addr and wdata.
  - Hit (valid && tag match): load returns word; store merges the word into the line and sets dirty. cpu_resp_valid pulses the next cycle, so hit latency is 1.
  - Miss with dirty victim: go to WB_REQ. Miss with clean or invalid victim: go to FILL_REQ.
- *_REQ states:
  - Entered only with mem_ready=1; if mem_ready=0, wait in *_REQ.
  - Drive mem_req_valid=1 for exactly one cycle, then go to *_WAIT_LO.
  - WB_REQ: mem_write=1, mem_addr={victim tag,index}, mem_data_out=victim line.
  - FILL_REQ: mem_write=0, mem_addr={req tag,index}.
  - mem_write, mem_addr and mem_data_out hold stable until the matching WAIT_HI exits.
- *_WAIT_LO: wait for mem_ready=0, then go to *_WAIT_HI. Memory lowers ready one cycle after sampling the request.
- *_WAIT_HI: wait for mem_ready=1.
  - WB: clear dirty, go to FILL_REQ.
  - FILL: capture mem_data_in in that same cycle; set valid and tag; apply a pending store merge and set dirty; a load keeps dirty=0. Go to RESP.
- RESP: cpu_resp_valid=1 for one cycle; cpu_rdata=selected word (0 for stores). Return to IDLE.
- Miss latency = memory delay (1-8 cycles) + 4 handshake cycles per transfer.
- Boundaries:
  - Back-to-back requests to the same line after a fill hit.
  - A store to the same line as the victim with a different tag evicts and then refills correctly.
  - A request arriving while busy is not accepted (cpu_req_ready=0).
  - cpu_req_valid dropping mid-miss has no effect; the latched request completes.
  - Index wrap at NUM_LINES-1 is handled with no special case.
- Assertions:
  - mem_req_valid never high while mem_ready=0.
  - Never two consecutive mem_req_valid cycles.
  - Exactly one response per accept.

Decomposition:
- Package cache_dm_pkg: state enum; localparams OFFSET_W, INDEX_W, TAG_W, WORDS_PER_LINE; line_t (packed byte array of BLOCK_BYTES) and tag-entry struct {valid, dirty, tag}.
- One sub-module, cache_dm_array: tag/valid/dirty plus data storage. It has a combinational read port by index, and a synchronous write port that takes a full line, or a word with word select.

Test Plan:
- Cold load to 0x100 after reset -> FILL_REQ with mem_addr=0x10, mem_write=0; one response with the word from mem_data_in; no write-back.
- Load 0x100 twice -> second response exactly 1 cycle after accept; no mem_req_valid.
- Store 0xDEADBEEF to 0x104, then load 0x104 -> hit returns 0xDEADBEEF; dirty set; no memory traffic.
- Dirty line at index 0 (tag A), load to tag B at index 0 (+0x400 with defaults) -> write-back at {A,0} with the merged line first, then fill at {B,0}; reload of tag A returns 0xDEADBEEF from memory.
- Memory delay swept 1..8 with mem_ready toggled per protocol -> correct data, exactly one mem_req_valid per transfer, assertions clean.
- rst asserted in FILL_WAIT_HI -> next cycle all outputs at reset values; the next load to the same address misses (valid cleared).

Source files
------------

// File: rtl/cache_dm_pkg.sv
// cache_dm_pkg: cache geometry, controller states, line/tag types and address field helpers
package cache_dm_pkg;
    localparam int ADDR_W = 32;
    localparam int BLOCK_BYTES = 16;
    localparam int WORD_BYTES = 4;
    localparam int NUM_LINES = 64;
    localparam int OFFSET_W = $clog2(BLOCK_BYTES);
    localparam int INDEX_W = $clog2(NUM_LINES);
    localparam int TAG_W = ADDR_W - OFFSET_W - INDEX_W;
    localparam int WORDS_PER_LINE = BLOCK_BYTES / WORD_BYTES;
    localparam int BYTE_OFF_W = $clog2(WORD_BYTES);
    localparam int WSEL_W = $clog2(WORDS_PER_LINE);
    localparam int WORD_W = 8 * WORD_BYTES;
    localparam int LINE_W = 8 * BLOCK_BYTES;
    localparam int BLK_ADDR_W = ADDR_W - OFFSET_W;

    typedef enum logic [2:0] {
        IDLE, WB_REQ, WB_WAIT_LO, WB_WAIT_HI, FILL_REQ, FILL_WAIT_LO, FILL_WAIT_HI, RESP
    } state_t;

    typedef logic [BLOCK_BYTES-1:0][7:0] line_t;

    typedef struct packed {
        logic             valid;
        logic             dirty;
        logic [TAG_W-1:0] tag;
    } tag_t;

    function automatic logic [INDEX_W-1:0] idx_of(input logic [ADDR_W-1:0] a);
        return a[OFFSET_W +: INDEX_W];
    endfunction

    function automatic logic [TAG_W-1:0] tag_of(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1 -: TAG_W];
    endfunction

    function automatic logic [WSEL_W-1:0] wsel_of(input logic [ADDR_W-1:0] a);
        return a[BYTE_OFF_W +: WSEL_W];
    endfunction

    function automatic logic [BLK_ADDR_W-1:0] blk_of(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1:OFFSET_W];
    endfunction

    function automatic logic [WORD_W-1:0] get_word(input line_t l, input logic [WSEL_W-1:0] s);
        return l[WORD_BYTES*s +: WORD_BYTES];
    endfunction

    function automatic line_t put_word(input line_t l, input logic [WSEL_W-1:0] s, input logic [WORD_W-1:0] w);
        line_t r;
        r = l;
        r[WORD_BYTES*s +: WORD_BYTES] = w;
        return r;
    endfunction
endpackage

// File: rtl/cache_dm_array.sv
// cache_dm_array: per-line valid/dirty/tag state and line data, combinational read, word or line write
module cache_dm_array
    import cache_dm_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [INDEX_W-1:0] idx,
    output tag_t               rd_tag,
    output line_t              rd_line,
    input  logic               tag_we,
    input  tag_t               wr_tag,
    input  logic               data_we,
    input  logic               word_we,
    input  logic [WSEL_W-1:0]  wr_sel,
    input  line_t              wr_line,
    input  logic [WORD_W-1:0]  wr_word
);
    logic [NUM_LINES-1:0] valid, dirty;
    logic [TAG_W-1:0] tags [NUM_LINES];
    line_t data [NUM_LINES];

    assign rd_tag = '{valid: valid[idx], dirty: dirty[idx], tag: tags[idx]};
    assign rd_line = data[idx];

    // Valid and dirty bits are the only storage cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
            dirty <= '0;
        end else if (tag_we) begin
            valid[idx] <= wr_tag.valid;
            dirty[idx] <= wr_tag.dirty;
        end
    end

    // Tag and line storage; a word write merges into the resident line
    always_ff @(posedge clk) begin
        if (tag_we) tags[idx] <= wr_tag.tag;
        if (data_we) data[idx] <= word_we ? put_word(data[idx], wr_sel, wr_word) : wr_line;
    end
endmodule

// File: rtl/cache_ctrl_dm.sv
// cache_ctrl_dm: direct-mapped write-back write-allocate cache controller in front of block memory
module cache_ctrl_dm
    import cache_dm_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req_valid,
    output logic                  cpu_req_ready,
    input  logic                  cpu_write,
    input  logic [ADDR_W-1:0]     cpu_addr,
    input  logic [WORD_W-1:0]     cpu_wdata,
    output logic                  cpu_resp_valid,
    output logic [WORD_W-1:0]     cpu_rdata,
    output logic                  mem_req_valid,
    output logic                  mem_write,
    output logic [BLK_ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0]     mem_data_out,
    input  logic [LINE_W-1:0]     mem_data_in,
    input  logic                  mem_ready
);
    state_t state;
    logic req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [WORD_W-1:0] req_wdata;
    logic [ADDR_W-1:0] cur_addr;
    tag_t rd_tag, wr_tag;
    line_t rd_line, wr_line;
    logic hit, store_hit, wb_done, fill_done;

    // In IDLE the array is looked up with the incoming address so hits answer next cycle
    assign cur_addr = state == IDLE ? cpu_addr : req_addr;
    assign hit = rd_tag.valid && rd_tag.tag == tag_of(cur_addr);
    assign store_hit = state == IDLE && cpu_req_valid && cpu_write && hit;
    assign wb_done = state == WB_WAIT_HI && mem_ready;
    assign fill_done = state == FILL_WAIT_HI && mem_ready;
    assign wr_tag = '{valid: 1'b1, dirty: store_hit || (fill_done && req_write),
                      tag: wb_done ? rd_tag.tag : tag_of(cur_addr)};
    assign wr_line = req_write ? put_word(mem_data_in, wsel_of(req_addr), req_wdata) : mem_data_in;

    cache_dm_array u_array (
        .clk(clk),
        .rst(rst),
        .idx(idx_of(cur_addr)),
        .rd_tag(rd_tag),
        .rd_line(rd_line),
        .tag_we(store_hit || wb_done || fill_done),
        .wr_tag(wr_tag),
        .data_we(store_hit || fill_done),
        .word_we(store_hit),
        .wr_sel(wsel_of(cur_addr)),
        .wr_line(wr_line),
        .wr_word(cpu_wdata)
    );

    // Walks each request through hit, write-back and refill; every output is registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cpu_req_ready <= 1'b1;
            cpu_resp_valid <= 1'b0;
            cpu_rdata <= '0;
            mem_req_valid <= 1'b0;
            mem_write <= 1'b0;
            mem_addr <= '0;
            mem_data_out <= '0;
        end else begin
            case (state)
                IDLE: if (cpu_req_valid) begin
                    cpu_req_ready <= 1'b0;
                    req_write <= cpu_write;
                    req_addr <= cpu_addr;
                    req_wdata <= cpu_wdata;
                    if (hit) begin
                        state <= RESP;
                        cpu_resp_valid <= 1'b1;
                        cpu_rdata <= cpu_write ? '0 : get_word(rd_line, wsel_of(cpu_addr));
                    end else begin
                        mem_req_valid <= mem_ready;
                        mem_write <= rd_tag.valid && rd_tag.dirty;
                        state <= rd_tag.valid && rd_tag.dirty ? WB_REQ : FILL_REQ;
                        mem_addr <= rd_tag.valid && rd_tag.dirty ? {rd_tag.tag, idx_of(cpu_addr)} : blk_of(cpu_addr);
                        mem_data_out <= rd_line;
                    end
                end
                WB_REQ, FILL_REQ: begin
                    mem_req_valid <= !mem_req_valid && mem_ready;
                    if (mem_req_valid) state <= state == WB_REQ ? WB_WAIT_LO : FILL_WAIT_LO;
                end
                WB_WAIT_LO: if (!mem_ready) state <= WB_WAIT_HI;
                FILL_WAIT_LO: if (!mem_ready) state <= FILL_WAIT_HI;
                WB_WAIT_HI: if (mem_ready) begin
                    state <= FILL_REQ;
                    mem_req_valid <= 1'b1;
                    mem_write <= 1'b0;
                    mem_addr <= blk_of(req_addr);
                end
                FILL_WAIT_HI: if (mem_ready) begin
                    state <= RESP;
                    cpu_resp_valid <= 1'b1;
                    cpu_rdata <= req_write ? '0 : get_word(mem_data_in, wsel_of(req_addr));
                end
                RESP: begin
                    state <= IDLE;
                    cpu_resp_valid <= 1'b0;
                    cpu_req_ready <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cache_ctrl_dm.sv
// tb_cache_ctrl_dm: directed scoreboard bench with a block memory model for the cache controller
module tb_cache_ctrl_dm;
    logic clk = 0, rst = 1;
    logic cpu_req_valid = 0, cpu_write = 0;
    logic [31:0] cpu_addr = 0, cpu_wdata = 0;
    logic cpu_req_ready, cpu_resp_valid, mem_req_valid, mem_write;
    logic [31:0] cpu_rdata;
    logic [27:0] mem_addr;
    logic [127:0] mem_data_out;
    logic [127:0] mem_data_in = 0;
    logic mem_ready = 1;

    int vecs = 0, errs = 0, cyc = 0, mem_delay = 3;
    int n_rd = 0, n_wr = 0, n_txn = 0, wr_seq = 0, rd_seq = 0, last_lat = 0;
    logic [27:0] last_rd_addr = 0, last_wr_addr = 0;
    logic [127:0] last_wr_data = 0;
    logic prev_mreq = 0;
    logic [127:0] mem_store [logic [27:0]];
    logic [31:0] ref_mem [logic [31:0]];

    typedef struct {
        logic [31:0] data;
        int          acc;
    } exp_t;
    exp_t sb [$];

    cache_ctrl_dm dut (
        .clk(clk), .rst(rst),
        .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
        .cpu_write(cpu_write), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_resp_valid(cpu_resp_valid), .cpu_rdata(cpu_rdata),
        .mem_req_valid(mem_req_valid), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_data_out(mem_data_out), .mem_data_in(mem_data_in), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] pat(input logic [31:0] a);
        return 32'hC0DE0000 + a;
    endfunction

    function automatic logic [127:0] blk_data(input logic [27:0] b);
        logic [127:0] r;
        if (mem_store.exists(b)) return mem_store[b];
        for (int w = 0; w < 4; w++) r[32*w +: 32] = pat({b, 4'h0} + 32'(4 * w));
        return r;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : pat(a);
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_rst_outputs();
        chk("rst_req_ready", cpu_req_ready, 1);
        chk("rst_resp_valid", cpu_resp_valid, 0);
        chk("rst_rdata", cpu_rdata, 0);
        chk("rst_mem_req_valid", mem_req_valid, 0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_data_out", mem_data_out, 0);
    endtask

    task automatic cpu_op(input logic w, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        int t = 0;
        @(negedge clk);
        cpu_req_valid = 1;
        cpu_write = w;
        cpu_addr = a;
        cpu_wdata = d;
        while (!cpu_req_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) begin
            vecs++;
            errs++;
            $display("FAIL accept_timeout: addr %0h never accepted", a);
            cpu_req_valid = 0;
            return;
        end
        e.data = w ? 32'h0 : ref_rd(a);
        e.acc = cyc;
        if (w) ref_mem[a] = d;
        sb.push_back(e);
        @(posedge clk);
        #1 cpu_req_valid = 0;
    endtask

    task automatic wait_done();
        int t = 0;
        while ((sb.size() != 0 || !cpu_req_ready) && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) begin
            vecs++;
            errs++;
            $display("FAIL resp_timeout: %0d responses outstanding, 0 required", sb.size());
            sb.delete();
        end
    endtask

    task automatic op(input logic w, input logic [31:0] a, input logic [31:0] d);
        cpu_op(w, a, d);
        wait_done();
    endtask

    // Block memory: samples a request, drops ready next cycle, completes after mem_delay cycles
    initial begin
        logic w;
        logic [27:0] a;
        logic [127:0] d;
        forever begin
            @(negedge clk);
            if (!rst && mem_req_valid) begin
                w = mem_write;
                a = mem_addr;
                d = mem_data_out;
                n_txn++;
                if (w) begin
                    n_wr++;
                    wr_seq = n_txn;
                    last_wr_addr = a;
                    last_wr_data = d;
                end else begin
                    n_rd++;
                    rd_seq = n_txn;
                    last_rd_addr = a;
                end
                @(posedge clk);
                #1 mem_ready = 0;
                repeat (mem_delay) @(posedge clk);
                #1;
                if (w) mem_store[a] = d;
                else mem_data_in = blk_data(a);
                mem_ready = 1;
            end
        end
    end

    // Response monitor and memory-request protocol checks
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && cpu_resp_valid) begin
                if (sb.size() == 0) begin
                    vecs++;
                    errs++;
                    $display("FAIL unexpected_resp: got rdata %0h with no request outstanding", cpu_rdata);
                end else begin
                    e = sb.pop_front();
                    chk("resp_rdata", cpu_rdata, e.data);
                    last_lat = cyc - e.acc;
                end
            end
            if (!rst && mem_req_valid) begin
                chk("mreq_with_ready_low", mem_ready, 1);
                chk("mreq_consecutive", prev_mreq, 0);
            end
            prev_mreq = mem_req_valid;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, w0, t0, t;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_rst_outputs();
        rst = 0;

        n0 = n_rd;
        w0 = n_wr;
        op(0, 32'h100, 0);
        chk("cold_fill_count", n_rd - n0, 1);
        chk("cold_fill_addr", last_rd_addr, 28'h10);
        chk("cold_no_wb", n_wr - w0, 0);

        t0 = n_txn;
        op(0, 32'h100, 0);
        chk("hit_latency", last_lat, 1);
        op(1, 32'h104, 32'hDEADBEEF);
        chk("store_hit_latency", last_lat, 1);
        op(0, 32'h104, 0);
        chk("hit_no_mem", n_txn - t0, 0);

        w0 = n_wr;
        op(0, 32'h500, 0);
        chk("evict_wb_count", n_wr - w0, 1);
        chk("evict_wb_addr", last_wr_addr, 28'h10);
        chk("evict_wb_data", last_wr_data, {pat(32'h10C), pat(32'h108), 32'hDEADBEEF, pat(32'h100)});
        chk("evict_fill_addr", last_rd_addr, 28'h50);
        chk("evict_wb_first", wr_seq < rd_seq, 1);
        w0 = n_wr;
        op(0, 32'h104, 0);
        chk("reload_no_wb", n_wr - w0, 0);
        chk("reload_fill_addr", last_rd_addr, 28'h10);

        mem_delay = 6;
        n0 = n_rd;
        cpu_op(0, 32'h900, 0);
        t = 0;
        while (mem_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("abort_fill_started", n_rd - n0, 1);
        repeat (2) @(negedge clk);
        rst = 1;
        sb.delete();
        @(negedge clk);
        chk_rst_outputs();
        rst = 0;
        t = 0;
        while (!mem_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        n0 = n_rd;
        op(0, 32'h104, 0);
        chk("post_rst_valid_cleared", n_rd - n0, 1);
        n0 = n_rd;
        op(0, 32'h900, 0);
        chk("post_rst_miss", n_rd - n0, 1);

        mem_delay = 2;
        cpu_op(0, 32'h3F0, 0);
        cpu_req_valid = 1;
        cpu_write = 0;
        cpu_addr = 32'h7F0;
        repeat (3) begin
            @(negedge clk);
            chk("busy_not_ready", cpu_req_ready, 0);
        end
        cpu_req_valid = 0;
        wait_done();
        op(1, 32'h7F4, 32'h12345678);
        chk("wrap_fill_addr", last_rd_addr, 28'h7F);
        w0 = n_wr;
        op(0, 32'h3F4, 0);
        chk("wrap_wb_count", n_wr - w0, 1);
        chk("wrap_wb_addr", last_wr_addr, 28'h7F);
        op(0, 32'h7F4, 0);

        for (int d = 1; d <= 8; d++) begin
            mem_delay = d;
            t0 = n_txn;
            op(1, 32'h1000 * d + 32'h20, 32'h5A000000 + d);
            op(0, 32'h1000 * d + 32'h20, 0);
            op(0, 32'h1000 * d + 32'h424, 0);
            chk("sweep_txns", n_txn - t0, 3);
        end
        op(0, 32'h1020, 0);

        chk("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
